ram_ctrl: RTL and testbench
===========================

# ram_ctrl

Request-side sequencer for the 256 x 32 single-port `ram` block. It accepts read and write commands from the host on a valid/ready handshake and drives the RAM pins `addr`, `wr_en`, `rd_en` and the bidirectional `data_io` with a fixed setup/strobe/hold sequence. It captures read data and returns it on a one-cycle response strobe. It sits directly upstream of `ram` and replaces bench-style task sequencing with synthesizable control.

## Interface
- `RD_LAT`, default 1: cycles after the `rd_en` strobe before `data_io` is sampled. Legal range 1..15.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  command present.
- `req_ready`  out  1  controller idle, command accepted when `req_valid && req_ready`.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  8  RAM word address.
- `req_wdata`  in  32  write data, ignored for reads.
- `rsp_valid`  out  1  one-cycle pulse, read data valid. No backpressure.
- `rsp_rdata`  out  32  captured read data, held until the next capture.
- `ram_addr`  out  8  to `ram.addr`.
- `ram_wr_en`  out  1  to `ram.wr_en`.
- `ram_rd_en`  out  1  to `ram.rd_en`.
- `ram_data_io`  inout  32  to `ram.data_io`. Driven only during write states, otherwise high-Z.
- `verify_err`  out  1  present only with `RAM_CTRL_WRVERIFY_EN`. See Configuration.

## Operation
- FSM states: `IDLE`, `SETUP`, `STROBE`, `HOLD`, `WAIT`.
- `req_ready` = (state == `IDLE`). It is combinational from the state register.
- `IDLE`: on accept, register addr, data and we, then go to `SETUP`.
- `SETUP`: `ram_addr` is valid. For a write, `ram_data_io` is driven. Strobes stay low. Next state is `STROBE`.
- `STROBE`: `ram_wr_en` (write) or `ram_rd_en` (read) is high for exactly this one cycle.
  - Write: go to `HOLD`.
  - Read: load the 4-bit counter with `RD_LAT - 1` and go to `WAIT`.
- `HOLD` (write only): addr and data are still driven, strobes low. Go to `IDLE`.
- `WAIT` (read only): bus released. When the counter reaches 0, sample `ram_data_io` into `rsp_rdata`, set `rsp_valid` for the next cycle, and go to `IDLE`. Otherwise decrement.
- `ram_addr` holds its last value in `IDLE`.
- `ram_wr_en` and `ram_rd_en` are never high together.
- Data driver enable is asserted only in `SETUP`, `STROBE` and `HOLD` of a write.
- Reset values: state `IDLE`, `req_ready` 1, `ram_addr` 0, `ram_wr_en` 0, `ram_rd_en` 0, `ram_data_io` high-Z, `rsp_valid` 0, `rsp_rdata` 0, `verify_err` 0.
- Reset mid-operation: abort immediately. Strobes drop and the bus is released on the cycle after the reset edge. No `rsp_valid` is issued for the aborted command.
- `req_*` inputs are don't-care while `req_ready` is 0.

## Timing
- Accept edge defines cycle 0.
- Write: `SETUP` c1, `STROBE` c2, `HOLD` c3, `req_ready` high c4. Throughput is 1 write per 4 cycles.
- Read: `SETUP` c1, `STROBE` c2, `WAIT` c3..c(2+RD_LAT), sample at the end of c(2+RD_LAT).
  - `rsp_valid` and `req_ready` are both high in c(3+RD_LAT).
  - Read throughput is 1 per (3+RD_LAT) cycles.
- A new command may be accepted in the same cycle that `rsp_valid` pulses.

## Configuration
- `RAM_CTRL_WRVERIFY_EN` defined:
  - After `HOLD`, a write performs an internal read of the same address (`SETUP`, `STROBE`, `WAIT`) without asserting `rsp_valid`.
  - The read-back word is compared with the written data. `verify_err` pulses for 1 cycle on mismatch, coincident with the return to `IDLE`.
  - Write occupancy becomes 6+RD_LAT cycles.
- Undefined: the `verify_err` port and the compare logic are absent. Writes end after `HOLD`.

## Structure
- `ram_ctrl_pkg`: state enum `ram_ctrl_state_t`, plus constants `RAM_AW=8`, `RAM_DW=32`, `RD_LAT_W=4`.
- Sub-module `ram_ctrl_iobuf`: 32-bit tristate buffer with ports `oe`, `dout`, `din`, `pad`. It isolates the inout from the FSM.

## Test plan
- Write 255←99, write 254←77, read 255, read 254 (RD_LAT=1) -> `rsp_rdata` = 99 then 77. Each `rsp_valid` appears 4 cycles after accept.
- `req_valid` held high with three queued writes -> each accept is spaced exactly 4 cycles apart, and `ram_wr_en` pulses are 1 cycle wide.
- RD_LAT=3, write 0x10←0xDEADBEEF then read 0x10 -> `rsp_valid` arrives 6 cycles after the read accept with 0xDEADBEEF, and the bus is high-Z throughout the read.
- `reset` asserted in `WAIT` of a read -> next cycle: `req_ready` 1, strobes 0, bus high-Z, and no `rsp_valid` ever issued.
- Strobe exclusivity and bus release checked on every cycle by assertion over random traffic.
- `RAM_CTRL_WRVERIFY_EN` with a RAM model forcing bit 0 stuck at 0: write 0x01←0x3 -> `verify_err` pulses once. Write 0x02←0x2 -> no pulse.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared types and sizes for the ram_ctrl request sequencer and its pad buffer.
package ram_ctrl_pkg;

  localparam int RAM_AW   = 8;
  localparam int RAM_DW   = 32;
  localparam int RD_LAT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    WAIT
  } ram_ctrl_state_t;

endpackage

// File: rtl/ram_ctrl_iobuf.sv
// Tristate pad buffer: keeps the bidirectional RAM data bus out of the control FSM.
module ram_ctrl_iobuf
  import ram_ctrl_pkg::*;
(
  input  logic              oe,
  input  logic [RAM_DW-1:0] dout,
  output logic [RAM_DW-1:0] din,
  inout  wire  [RAM_DW-1:0] pad
);

  assign pad = oe ? dout : {RAM_DW{1'bz}};
  assign din = pad;

endmodule

// File: rtl/ram_ctrl.sv
// Host-to-RAM sequencer: setup/strobe/hold write and setup/strobe/wait read cycles.
// Optional write read-back check enabled by defining RAM_CTRL_WRVERIFY_EN.
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [RAM_AW-1:0] req_addr,
  input  logic [RAM_DW-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [RAM_DW-1:0] rsp_rdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_wr_en,
  output logic              ram_rd_en,
  inout  wire  [RAM_DW-1:0] ram_data_io
`ifdef RAM_CTRL_WRVERIFY_EN
  ,
  output logic              verify_err
`endif
);

  ram_ctrl_state_t     state_q;
  logic [RAM_AW-1:0]   addr_q;
  logic [RAM_DW-1:0]   wdata_q;
  logic                we_q;
  logic [RD_LAT_W-1:0] cnt_q;
  logic                wr_en_q;
  logic                rd_en_q;
  logic                oe_q;
  logic                rsp_valid_q;
  logic [RAM_DW-1:0]   rdata_q;
  logic [RAM_DW-1:0]   din;
`ifdef RAM_CTRL_WRVERIFY_EN
  logic                vfy_q;
  logic                verify_err_q;
`endif

  ram_ctrl_iobuf u_iobuf (
    .oe   (oe_q),
    .dout (wdata_q),
    .din  (din),
    .pad  (ram_data_io)
  );

  // NOTE: every register here is updated with <= so all branches see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      oe_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
`ifdef RAM_CTRL_WRVERIFY_EN
      vfy_q        <= 1'b0;
      verify_err_q <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
`ifdef RAM_CTRL_WRVERIFY_EN
      verify_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            we_q    <= req_we;
            oe_q    <= req_we;
`ifdef RAM_CTRL_WRVERIFY_EN
            vfy_q   <= 1'b0;
`endif
            state_q <= SETUP;
          end
        end
        SETUP: begin
          wr_en_q <= we_q;
          rd_en_q <= ~we_q;
          state_q <= STROBE;
        end
        STROBE: begin
          wr_en_q <= 1'b0;
          rd_en_q <= 1'b0;
          if (we_q) begin
            state_q <= HOLD;
          end else begin
            cnt_q   <= RD_LAT_W'(RD_LAT - 1);
            state_q <= WAIT;
          end
        end
        HOLD: begin
          oe_q <= 1'b0;
`ifdef RAM_CTRL_WRVERIFY_EN
          // Re-run the same address as an internal read to check what landed.
          we_q    <= 1'b0;
          vfy_q   <= 1'b1;
          state_q <= SETUP;
`else
          state_q <= IDLE;
`endif
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
`ifdef RAM_CTRL_WRVERIFY_EN
            if (vfy_q) begin
              verify_err_q <= (din != wdata_q);
              vfy_q        <= 1'b0;
            end else begin
              rdata_q     <= din;
              rsp_valid_q <= 1'b1;
            end
`else
            rdata_q     <= din;
            rsp_valid_q <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign ram_addr  = addr_q;
  assign ram_wr_en = wr_en_q;
  assign ram_rd_en = rd_en_q;
`ifdef RAM_CTRL_WRVERIFY_EN
  assign verify_err = verify_err_q;
`endif

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: two instances (RD_LAT 1 and 3), each on its own behavioural RAM.
module tb_ram_ctrl;

`ifdef RAM_CTRL_WRVERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        stuck0;
  logic        req_valid [2];
  logic        req_we    [2];
  logic [7:0]  req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic [7:0]  ram_addr  [2];
  logic        ram_wr_en [2];
  logic        ram_rd_en [2];
  logic        oe        [2];
`ifdef RAM_CTRL_WRVERIFY_EN
  logic        verify_err [2];
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] ref_mem [2][256];
  bit          written [2][256];
  logic [31:0] last_rd [2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = (g == 0) ? 1 : 3;
    wire  [31:0] bus;
    logic [31:0] mem [256];
    logic [3:0]  rd_cnt;
    logic [7:0]  rd_addr;

    ram_ctrl #(.RD_LAT(LAT)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid[g]),
      .req_ready   (req_ready[g]),
      .req_we      (req_we[g]),
      .req_addr    (req_addr[g]),
      .req_wdata   (req_wdata[g]),
      .rsp_valid   (rsp_valid[g]),
      .rsp_rdata   (rsp_rdata[g]),
      .ram_addr    (ram_addr[g]),
      .ram_wr_en   (ram_wr_en[g]),
      .ram_rd_en   (ram_rd_en[g]),
      .ram_data_io (bus)
`ifdef RAM_CTRL_WRVERIFY_EN
      ,
      .verify_err  (verify_err[g])
`endif
    );

    assign oe[g] = dut.u_iobuf.oe;

    // RAM model: presents read data only in the single cycle RD_LAT cycles after the strobe.
    always @(posedge clk) begin
      if (reset) begin
        rd_cnt <= 4'd0;
      end else begin
        if (ram_wr_en[g]) mem[ram_addr[g]] <= bus & ~{31'b0, stuck0};
        if (ram_rd_en[g]) begin
          rd_cnt  <= 4'(LAT);
          rd_addr <= ram_addr[g];
        end else if (rd_cnt != 4'd0) begin
          rd_cnt <= rd_cnt - 4'd1;
        end
      end
    end

    assign bus = (rd_cnt == 4'd1) ? mem[rd_addr] : 32'bz;
  end

  function automatic int lat_of(input int l);
    return (l == 0) ? 1 : 3;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobes must never overlap, on either instance, on any cycle.
  always @(negedge clk) begin
    if (!reset) begin
      for (int l = 0; l < 2; l++) check("strobe_excl", {63'b0, ram_wr_en[l] & ram_rd_en[l]}, 64'd0);
    end
  end

  // One complete command: records per-cycle pin activity and compares against the timing rules.
  task automatic do_cmd(input int l, input logic we, input logic [7:0] addr, input logic [31:0] wdata);
    logic [63:0] wr_m, rd_m, oe_m, rsp_m, ve_m;
    logic [63:0] exp_wr, exp_rd, exp_oe, exp_rsp, exp_ve;
    logic [7:0]  a1;
    int k, t, done_exp, lat;
    lat  = lat_of(l);
    wr_m = '0; rd_m = '0; oe_m = '0; rsp_m = '0; ve_m = '0; a1 = '0;
    t = 0;
    while (!req_ready[l] && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("ready_before_cmd", {63'b0, req_ready[l]}, 64'd1);
    req_valid[l] = 1'b1; req_we[l] = we; req_addr[l] = addr; req_wdata[l] = wdata;
    @(negedge clk);
    req_valid[l] = 1'b0; req_we[l] = 1'($urandom);
    req_addr[l] = 8'($urandom); req_wdata[l] = $urandom;
    k = 1;
    while (k < 60) begin
      if (k == 1) a1 = ram_addr[l];
      wr_m[k]  = ram_wr_en[l];
      rd_m[k]  = ram_rd_en[l];
      oe_m[k]  = oe[l];
      rsp_m[k] = rsp_valid[l];
`ifdef RAM_CTRL_WRVERIFY_EN
      ve_m[k]  = verify_err[l];
`endif
      if (req_ready[l]) break;
      @(negedge clk);
      k++;
    end
    if (we) begin
      done_exp = VERIFY ? 6 + lat : 4;
      exp_wr   = 64'd1 << 2;
      exp_rd   = VERIFY ? (64'd1 << 5) : 64'd0;
      exp_oe   = 64'b1110;
      exp_rsp  = 64'd0;
      exp_ve   = (VERIFY && stuck0 && wdata[0]) ? (64'd1 << done_exp) : 64'd0;
      ref_mem[l][addr] = stuck0 ? (wdata & ~32'd1) : wdata;
      written[l][addr] = 1'b1;
    end else begin
      done_exp   = 3 + lat;
      exp_wr     = 64'd0;
      exp_rd     = 64'd1 << 2;
      exp_oe     = 64'd0;
      exp_rsp    = 64'd1 << done_exp;
      exp_ve     = 64'd0;
      last_rd[l] = ref_mem[l][addr];
    end
    check("done_cycle", 64'(k), 64'(done_exp));
    check("addr_c1", {56'b0, a1}, {56'b0, addr});
    check("addr_hold_idle", {56'b0, ram_addr[l]}, {56'b0, addr});
    check("wr_en_cycles", wr_m, exp_wr);
    check("rd_en_cycles", rd_m, exp_rd);
    check("bus_drive_cycles", oe_m, exp_oe);
    check("rsp_valid_cycles", rsp_m, exp_rsp);
    check("rsp_rdata", {32'b0, rsp_rdata[l]}, {32'b0, last_rd[l]});
    if (VERIFY) check("verify_err_cycles", ve_m, exp_ve);
  endtask

  initial begin
    logic [31:0] qd [3];
    int acc [3];
    int n, hi, dbl, rsp_seen;
    logic prev;

    reset  = 1'b1;
    stuck0 = 1'b0;
    for (int l = 0; l < 2; l++) begin
      req_valid[l] = 1'b0; req_we[l] = 1'b0; req_addr[l] = '0; req_wdata[l] = '0;
      last_rd[l] = '0;
    end
    repeat (3) @(negedge clk);

    // Reset values
    for (int l = 0; l < 2; l++) begin
      check("rst_ready",     {63'b0, req_ready[l]}, 64'd1);
      check("rst_ram_addr",  {56'b0, ram_addr[l]}, 64'd0);
      check("rst_wr_en",     {63'b0, ram_wr_en[l]}, 64'd0);
      check("rst_rd_en",     {63'b0, ram_rd_en[l]}, 64'd0);
      check("rst_bus_drive", {63'b0, oe[l]}, 64'd0);
      check("rst_rsp_valid", {63'b0, rsp_valid[l]}, 64'd0);
      check("rst_rsp_rdata", {32'b0, rsp_rdata[l]}, 64'd0);
`ifdef RAM_CTRL_WRVERIFY_EN
      check("rst_verify_err", {63'b0, verify_err[l]}, 64'd0);
`endif
    end
    reset = 1'b0;
    @(negedge clk);

    // Basic write/read pair at RD_LAT=1
    do_cmd(0, 1'b1, 8'd255, 32'd99);
    do_cmd(0, 1'b1, 8'd254, 32'd77);
    do_cmd(0, 1'b0, 8'd255, 32'd0);
    check("read_255_is_99", {32'b0, rsp_rdata[0]}, 64'd99);
    do_cmd(0, 1'b0, 8'd254, 32'd0);
    check("read_254_is_77", {32'b0, rsp_rdata[0]}, 64'd77);

    // Three writes queued behind a permanently-valid request
    for (int i = 0; i < 3; i++) qd[i] = $urandom;
    n = 0; hi = 0; dbl = 0; prev = 1'b0;
    req_valid[0] = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (n == 3) req_valid[0] = 1'b0;
      if (n < 3 && req_ready[0]) begin
        req_we[0] = 1'b1; req_addr[0] = 8'(10 + n); req_wdata[0] = qd[n];
        acc[n] = t;
        n++;
      end
      if (ram_wr_en[0]) begin
        hi++;
        if (prev) dbl++;
      end
      prev = ram_wr_en[0];
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    check("queued_accepts", 64'(n), 64'd3);
    check("accept_gap_1", 64'(acc[1] - acc[0]), VERIFY ? 64'd7 : 64'd4);
    check("accept_gap_2", 64'(acc[2] - acc[1]), VERIFY ? 64'd7 : 64'd4);
    check("wr_en_pulse_count", 64'(hi), 64'd3);
    check("wr_en_wide_pulses", 64'(dbl), 64'd0);
    for (int i = 0; i < 3; i++) begin
      ref_mem[0][10 + i] = qd[i];
      written[0][10 + i] = 1'b1;
    end
    for (int i = 0; i < 3; i++) do_cmd(0, 1'b0, 8'(10 + i), 32'd0);

    // RD_LAT=3 instance
    do_cmd(1, 1'b1, 8'h10, 32'hDEADBEEF);
    do_cmd(1, 1'b0, 8'h10, 32'd0);
    check("rdlat3_data", {32'b0, rsp_rdata[1]}, 64'hDEADBEEF);

    // Reset while a read sits in WAIT
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 8'h10;
    @(negedge clk);
    req_valid[1] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_ready",     {63'b0, req_ready[1]}, 64'd1);
    check("abort_wr_en",     {63'b0, ram_wr_en[1]}, 64'd0);
    check("abort_rd_en",     {63'b0, ram_rd_en[1]}, 64'd0);
    check("abort_bus_drive", {63'b0, oe[1]}, 64'd0);
    check("abort_rsp_rdata", {32'b0, rsp_rdata[1]}, 64'd0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    rsp_seen = 0;
    for (int t = 0; t < 12; t++) begin
      if (rsp_valid[1]) rsp_seen++;
      @(negedge clk);
    end
    check("abort_no_rsp", 64'(rsp_seen), 64'd0);

    // Random traffic on both instances against the reference memory
    for (int i = 0; i < 30; i++) begin
      int l;
      logic [7:0] a;
      l = int'($urandom_range(1, 0));
      a = 8'(32 + $urandom_range(7, 0));
      if (!written[l][a] || $urandom_range(1, 0) == 0) do_cmd(l, 1'b1, a, $urandom);
      else do_cmd(l, 1'b0, a, 32'd0);
    end

`ifdef RAM_CTRL_WRVERIFY_EN
    // Read-back check against a RAM with bit 0 stuck low
    stuck0 = 1'b1;
    do_cmd(0, 1'b1, 8'h01, 32'h3);
    do_cmd(0, 1'b1, 8'h02, 32'h2);
    stuck0 = 1'b0;
    do_cmd(0, 1'b0, 8'h01, 32'd0);
    check("stuck_readback", {32'b0, rsp_rdata[0]}, 64'h2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
